// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver feeding a packet parser that holds one checked
// command for the life engine behind a valid/ready handshake.
//
// Packet (7 bytes): 0xA5 | OPC | A0 | A1 | A2 | A3 | CHK
//   cmd      = OPC[2:0]      (OPC[7:3] must be zero)
//   cmd_arg0 = {A3,A2,A1,A0}
//   CHK      = OPC ^ A0 ^ A1 ^ A2 ^ A3
//
// Handshake: cmd/cmd_arg0 are valid while cmd_valid=1 and stay stable until a
// transfer, which happens on a clk edge where cmd_valid & cmd_ready are both 1.
// cmd_valid is 0 the cycle after a transfer and never drops otherwise (except on
// reset). cmd_ready may be high before cmd_valid rises. cmd/cmd_arg0 keep their
// value after the transfer.

module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [2:0]  cmd,
  output logic [31:0] cmd_arg0,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic [2:0]  rx_state_dbg,
  output logic [2:0]  parse_state_dbg
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC_BYTE     = 8'hA5;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4   // bad stop bit seen; wait for the line to return high
  } rx_state_t;

  typedef enum logic [2:0] {
    P_HUNT = 3'd0,
    P_OPC  = 3'd1,
    P_ARG  = 3'd2,
    P_CHK  = 3'd3,
    P_HOLD = 3'd4
  } p_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;
  logic rx_fall_d;

  // Two-flop synchronizer for the asynchronous line, plus a delayed copy for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Only a genuine high-to-low transition starts a byte; a line stuck low does not.
  assign rx_fall_d = rx_prev_q & ~rx_s_q;

  // ---------------------------------------------------------------------------
  // Serial receiver
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_q;
  logic          byte_stb_q;
  logic          rx_ferr_q;

  // Receiver FSM: mid-bit sampling, LSB first, one-cycle byte strobe on a good stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      byte_stb_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      byte_stb_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_fall_d) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == CNT_HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A start bit that is no longer low at mid-bit was a glitch.
            rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              byte_q     <= shift_q;
              byte_stb_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_ferr_q  <= 1'b1;
              rx_state_q <= RX_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_BREAK: begin
          cnt_q <= '0;
          if (rx_s_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
          cnt_q      <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Packet parser and command holding register
  // ---------------------------------------------------------------------------
  p_state_t    p_state_q;
  logic [1:0]  arg_idx_q;
  logic [7:0]  opc_q;
  logic [7:0]  chk_q;
  logic [31:0] arg_acc_q;
  logic [2:0]  cmd_q;
  logic [31:0] cmd_arg0_q;
  logic        cmd_valid_q;
  logic        frame_err_q;
  logic        overrun_q;

  // Parser FSM: assembles the packet, validates it, and holds it until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_q   <= P_HUNT;
      arg_idx_q   <= '0;
      opc_q       <= '0;
      chk_q       <= '0;
      arg_acc_q   <= '0;
      cmd_q       <= '0;
      cmd_arg0_q  <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Receiver stop-bit errors and parser errors never coincide in one cycle.
      frame_err_q <= rx_ferr_q;
      overrun_q   <= 1'b0;
      case (p_state_q)
        P_HUNT: begin
          if (byte_stb_q && (byte_q == SYNC_BYTE)) begin
            p_state_q <= P_OPC;
          end
        end
        P_OPC: begin
          if (byte_stb_q) begin
            // A bad opcode is stored anyway and rejected with the checksum.
            opc_q     <= byte_q;
            chk_q     <= byte_q;
            arg_idx_q <= '0;
            p_state_q <= P_ARG;
          end
        end
        P_ARG: begin
          if (byte_stb_q) begin
            arg_acc_q[{arg_idx_q, 3'b000} +: 8] <= byte_q;
            chk_q <= chk_q ^ byte_q;
            if (arg_idx_q == 2'd3) begin
              p_state_q <= P_CHK;
            end else begin
              arg_idx_q <= arg_idx_q + 1'b1;
            end
          end
        end
        P_CHK: begin
          if (byte_stb_q) begin
            if ((byte_q != chk_q) || (opc_q[7:3] != 5'd0)) begin
              frame_err_q <= 1'b1;
              p_state_q   <= P_HUNT;
            end else begin
              cmd_q       <= opc_q[2:0];
              cmd_arg0_q  <= arg_acc_q;
              cmd_valid_q <= 1'b1;
              p_state_q   <= P_HOLD;
            end
          end
        end
        P_HOLD: begin
          // Bytes arriving while a command is held are lost, including in the
          // transfer cycle; the held command itself is never disturbed.
          if (byte_stb_q) begin
            overrun_q <= 1'b1;
          end
          if (cmd_valid_q && cmd_ready) begin
            cmd_valid_q <= 1'b0;
            p_state_q   <= P_HUNT;
          end
        end
        default: begin
          p_state_q <= P_HUNT;
        end
      endcase
      // A framing error abandons a partial packet but never a held command.
      if (rx_ferr_q && (p_state_q != P_HOLD)) begin
        p_state_q <= P_HUNT;
      end
    end
  end

  assign cmd             = cmd_q;
  assign cmd_arg0        = cmd_arg0_q;
  assign cmd_valid       = cmd_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
  assign rx_state_dbg    = rx_state_q;
  assign parse_state_dbg = p_state_q;

endmodule
